// File: rtl/tick_gen.sv
// tick_gen: NUM_CH-channel programmable clock/tick divider with glitch-free reprogramming.
// Optional combinational divisor readback when TICK_GEN_READBACK_EN is defined.
module tick_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 32,
  parameter logic [NUM_CH*CNT_W-1:0] INIT_DIV =
    {32'd99_999, 32'd16_666_666, 32'd24_999_999, 32'd49_999_999},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef TICK_GEN_READBACK_EN
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_div,
  output logic              rd_pend,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pend;
  logic [CNT_W-1:0]  div_all [NUM_CH];
  logic              sel_pend;

  // Out-of-range channels match nothing, so they read as ready.
  always_comb begin
    sel_pend = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) sel_pend = pend[i];
    end
  end

  assign cfg_ready = ~sel_pend;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pdiv;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;
    logic             act;
    logic             term;
    logic             hit;

    assign act  = en & ch_en[g] & ~sync_clr;
    assign term = (cnt == div);
    assign hit  = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        div    <= INIT_DIV[g*CNT_W +: CNT_W];
        pdiv   <= '0;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (sync_clr) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
        if (hit) div <= cfg_div;
        else if (pend_q) div <= pdiv;
      end else if (act) begin
        if (term) begin
          cnt    <= '0;
          clk_q  <= ~clk_q;
          tick_q <= 1'b1;
          if (pend_q) begin
            div    <= pdiv;
            pend_q <= 1'b0;
          end
        end else begin
          cnt    <= cnt + 1'b1;
          tick_q <= 1'b0;
        end
        // A write landing on a terminal count waits for the next one.
        if (hit) begin
          pdiv   <= cfg_div;
          pend_q <= 1'b1;
        end
      end else begin
        tick_q <= 1'b0;
        if (hit) begin
          div <= cfg_div;
          cnt <= '0;
        end
      end
    end

    assign pend[g]    = pend_q;
    assign div_all[g] = div;
    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
  end

`ifdef TICK_GEN_READBACK_EN
  always_comb begin
    rd_div  = '0;
    rd_pend = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        rd_div  = div_all[i];
        rd_pend = pend[i];
      end
    end
  end
`else
  logic unused_div;
  always_comb begin
    unused_div = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      unused_div = unused_div ^ (^div_all[i]);
    end
  end
`endif

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: scoreboard bench for tick_gen (2 channels, 8-bit divisors),
// plus a 3-channel instance to exercise an out-of-range cfg_ch.
module tb_tick_gen;
  localparam int N = 2;
  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic [N-1:0] ch_en = '0;
  logic         sync_clr = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [0:0]   cfg_ch = '0;
  logic [W-1:0] cfg_div = '0;
  logic [N-1:0] clk_out;
  logic [N-1:0] tick;

  logic         cfg_valid3 = 1'b0;
  logic         cfg_ready3;
  logic [1:0]   cfg_ch3 = '0;
  logic [W-1:0] cfg_div3 = '0;
  logic [2:0]   ch_en3 = 3'b111;
  logic [2:0]   clk_out3;
  logic [2:0]   tick3;

  typedef struct packed {
    logic [1:0] c;
    logic [1:0] t;
    logic [1:0] m;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] sb3[$];
  exp_t       e;
  logic [5:0] e3;
  int         checks = 0;
  int         errors = 0;

  tick_gen #(
    .NUM_CH(N), .CNT_W(W), .INIT_DIV({8'd0, 8'd3})
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .ch_en(ch_en),
    .sync_clr(sync_clr), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick)
  );

  tick_gen #(
    .NUM_CH(3), .CNT_W(W), .INIT_DIV({8'd1, 8'd0, 8'd3})
  ) dut3 (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .ch_en(ch_en3),
    .sync_clr(sync_clr), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_ch(cfg_ch3), .cfg_div(cfg_div3), .clk_out(clk_out3), .tick(tick3)
  );

  always #5 clk_in = ~clk_in;

  function automatic exp_t mk(bit c1, bit c0, bit t1, bit t0);
    return exp_t'({c1, c0, t1, t0, 2'b11});
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    en = 1'b1;
    ch_en = 2'b11;
    sync_clr = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_valid3 = 1'b0;
    cfg_ch3 = '0;
    sb.delete();
    sb3.delete();
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1;
    ch_en = 2'b11;
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if (clk_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_clk_out got %b want 00", clk_out);
    end
    checks++;
    if (tick !== 2'b00) begin
      errors++;
      $display("FAIL reset_tick got %b want 00", tick);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", cfg_ready);
    end
    checks++;
    if ({clk_out3, tick3} !== 6'b0) begin
      errors++;
      $display("FAIL reset_dut3 got %b want 000000", {clk_out3, tick3});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run();
    apply_reset();
    for (int k = 1; k <= 12; k++)
      sb.push_back(mk(k % 2 == 1, (k / 4) % 2 == 1, 1'b1, k % 4 == 0));
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_in);
      #1 e = sb.pop_front();
      checks++;
      if ((clk_out & e.m) !== (e.c & e.m) || (tick & e.m) !== (e.t & e.m)) begin
        errors++;
        $display("FAIL run k=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                 k, clk_out, tick, e.c, e.t);
      end
    end
  endtask

  task automatic test_cfg();
    apply_reset();
    for (int k = 1; k <= 10; k++)
      sb.push_back(mk(k % 2 == 1, k >= 4 && ((k - 4) / 2) % 2 == 0, 1'b1,
                      k >= 4 && k % 2 == 0));
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_in);
      #1 e = sb.pop_front();
      checks++;
      if ((clk_out & e.m) !== (e.c & e.m) || (tick & e.m) !== (e.t & e.m)) begin
        errors++;
        $display("FAIL cfg k=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                 k, clk_out, tick, e.c, e.t);
      end
      if (k <= 4) begin
        checks++;
        if (cfg_ready !== (k == 1 || k == 4)) begin
          errors++;
          $display("FAIL cfg_ready k=%0d got %b want %b", k, cfg_ready, k == 1 || k == 4);
        end
      end
      if (k == 1) begin
        cfg_valid = 1'b1;
        cfg_ch = 1'b0;
        cfg_div = 8'd1;
      end
      if (k == 2) cfg_div = 8'd7;
      if (k == 4) cfg_valid = 1'b0;
    end
  endtask

  task automatic test_hold();
    apply_reset();
    for (int k = 1; k <= 15; k++)
      sb.push_back(mk(k % 2 == 1, k >= 14, 1'b1, k == 14));
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk_in);
      #1 e = sb.pop_front();
      checks++;
      if ((clk_out & e.m) !== (e.c & e.m) || (tick & e.m) !== (e.t & e.m)) begin
        errors++;
        $display("FAIL hold k=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                 k, clk_out, tick, e.c, e.t);
      end
      if (k == 2) ch_en = 2'b10;
      if (k == 12) ch_en = 2'b11;
    end
  endtask

  task automatic test_sync();
    apply_reset();
    for (int k = 1; k <= 15; k++) begin
      if (k <= 2) sb.push_back(mk(k % 2 == 1, 1'b0, 1'b1, 1'b0));
      else if (k == 3) sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
      else sb.push_back(mk((k - 3) % 2 == 1, k >= 9 && k < 15, 1'b1,
                           k == 9 || k == 15));
    end
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk_in);
      #1 e = sb.pop_front();
      checks++;
      if ((clk_out & e.m) !== (e.c & e.m) || (tick & e.m) !== (e.t & e.m)) begin
        errors++;
        $display("FAIL sync k=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                 k, clk_out, tick, e.c, e.t);
      end
      if (k == 2 || k == 3) begin
        checks++;
        if (cfg_ready !== (k == 3)) begin
          errors++;
          $display("FAIL sync_ready k=%0d got %b want %b", k, cfg_ready, k == 3);
        end
      end
      if (k == 1) begin
        cfg_valid = 1'b1;
        cfg_ch = 1'b0;
        cfg_div = 8'd5;
      end
      if (k == 2) begin
        cfg_valid = 1'b0;
        sync_clr = 1'b1;
      end
      if (k == 3) sync_clr = 1'b0;
    end
  endtask

  task automatic test_rst_mid();
    apply_reset();
    for (int k = 1; k <= 5; k++)
      sb.push_back(mk(k % 2 == 1, k >= 4, 1'b1, k == 4));
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_in);
      #1 e = sb.pop_front();
      checks++;
      if ((clk_out & e.m) !== (e.c & e.m) || (tick & e.m) !== (e.t & e.m)) begin
        errors++;
        $display("FAIL rst_pre k=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                 k, clk_out, tick, e.c, e.t);
      end
      if (k == 4) begin
        cfg_valid = 1'b1;
        cfg_ch = 1'b0;
        cfg_div = 8'd6;
      end
    end
    cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (clk_out !== 2'b00 || tick !== 2'b00) begin
      errors++;
      $display("FAIL rst_async clk_out=%b tick=%b want 00 00", clk_out, tick);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_pend_clear got %b want 1", cfg_ready);
    end
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 9; k++)
      sb.push_back(mk(k % 2 == 1, (k / 4) % 2 == 1, 1'b1, k % 4 == 0));
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk_in);
      #1 e = sb.pop_front();
      checks++;
      if ((clk_out & e.m) !== (e.c & e.m) || (tick & e.m) !== (e.t & e.m)) begin
        errors++;
        $display("FAIL rst_post k=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                 k, clk_out, tick, e.c, e.t);
      end
    end
  endtask

  task automatic test_oor();
    apply_reset();
    for (int k = 1; k <= 12; k++)
      sb3.push_back({1'((k / 2) % 2), 1'(k % 2), 1'((k / 4) % 2),
                     k % 2 == 0, 1'b1, k % 4 == 0});
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_in);
      #1 e3 = sb3.pop_front();
      checks++;
      if ({clk_out3, tick3} !== e3) begin
        errors++;
        $display("FAIL oor k=%0d clk_out=%b tick=%b want clk_out=%b tick=%b",
                 k, clk_out3, tick3, e3[5:3], e3[2:0]);
      end
      if (k == 1) begin
        cfg_valid3 = 1'b1;
        cfg_ch3 = 2'd3;
        cfg_div3 = 8'd0;
      end
      checks++;
      if (cfg_ready3 !== 1'b1) begin
        errors++;
        $display("FAIL oor_ready k=%0d got %b want 1", k, cfg_ready3);
      end
    end
    cfg_valid3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_cfg();
    test_hold();
    test_sync();
    test_rst_mid();
    test_oor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
